// File: rtl/wb_master_bridge_if.sv
// Bundle of the core-side request/response stream and the Wishbone B4 classic master signals.
// master modport: bridge view (drives mem_req_ready, response, busy and wbm_*_o).
// slave modport: environment view (core requester plus Wishbone slave).
interface wb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    // Core request stream
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    // Core response
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp_err;
    logic              mem_resp_timeout;
    logic              busy;
    // Wishbone master
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic              wbm_stb_o;
    logic              wbm_cyc_o;
    logic              wbm_ack_i;
    logic              wbm_err_i;

    modport master (
        input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err, mem_resp_timeout, busy,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );

    modport slave (
        output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err, mem_resp_timeout, busy,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Core valid/ready memory requests to Wishbone B4 classic single read/write cycles.
// Requests are queued in a REQ_DEPTH FIFO and issued one bus cycle at a time; each cycle ends on
// ACK, ERR or (TIMEOUT != 0) after TIMEOUT cycles, producing one in-order response pulse.
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   bus       wb_master_bridge_if.master: request stream, response, busy, Wishbone master
module wb_master_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned TIMEOUT   = 256
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    wb_master_bridge_if.master bus
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(REQ_DEPTH);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } req_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01
    } state_e;

    req_t              fifo_q [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop, fifo_full, fifo_empty;
    req_t              push_entry, head;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              cyc_q, cyc_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_timeout_q, resp_timeout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign fifo_full  = (count_q == (PTR_W + 1)'(REQ_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Ready depends only on registered state; held low while reset is asserted.
    assign bus.mem_req_ready = ~fifo_full & ~wb_rst_i;
    assign push = bus.mem_req_valid & ~fifo_full;

    always_comb begin
        push_entry.we  = bus.mem_we;
        // An empty byte mask means a full-word access.
        push_entry.sel = (bus.mem_be == '0) ? '1 : bus.mem_be;
        push_entry.adr = bus.mem_addr;
        push_entry.dat = bus.mem_wdata;
    end

    assign head = fifo_q[rd_ptr_q];

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        adr_d          = adr_q;
        dat_d          = dat_q;
        we_d           = we_q;
        sel_d          = sel_q;
        cyc_d          = cyc_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_timeout_d = 1'b0;
        rdata_d        = rdata_q;
        pop            = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    adr_d   = head.adr;
                    dat_d   = head.dat;
                    we_d    = head.we;
                    sel_d   = head.sel;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (bus.wbm_err_i) begin
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    rdata_d      = '0;
                    state_d      = StIdle;
                end else if (bus.wbm_ack_i) begin
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = we_q ? '0 : bus.wbm_dat_i;
                    state_d      = StIdle;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    cyc_d          = 1'b0;
                    we_d           = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_timeout_d = 1'b1;
                    rdata_d        = '0;
                    state_d        = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            adr_q          <= '0;
            dat_q          <= '0;
            we_q           <= 1'b0;
            sel_q          <= '0;
            cyc_q          <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            rdata_q        <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            adr_q          <= adr_d;
            dat_q          <= dat_d;
            we_q           <= we_d;
            sel_q          <= sel_d;
            cyc_q          <= cyc_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            rdata_q        <= rdata_d;
        end
    end

    assign bus.wbm_adr_o        = adr_q;
    assign bus.wbm_dat_o        = dat_q;
    assign bus.wbm_we_o         = we_q;
    assign bus.wbm_sel_o        = sel_q;
    assign bus.wbm_cyc_o        = cyc_q;
    assign bus.wbm_stb_o        = cyc_q;
    assign bus.mem_resp_valid   = resp_valid_q;
    assign bus.mem_resp_err     = resp_err_q;
    assign bus.mem_resp_timeout = resp_timeout_q;
    assign bus.mem_rdata        = rdata_q;
    assign bus.busy             = ~fifo_empty | (state_q == StBus);

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge (DATA_W=64, REQ_DEPTH=2, TIMEOUT=8): directed steps then random
// traffic, checked against a transaction-level model with a scripted Wishbone slave.
module tb_wb_master_bridge;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TO    = 8;

    // Slave reply kinds: 0 ack, 1 err, 2 ack+err together, 3 silent
    typedef struct {
        int          kind;
        int          delay;
        logic [63:0] data;
    } plan_t;
    typedef struct {
        logic        we;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [63:0] dat;
    } req_t;
    typedef struct {
        logic        err;
        logic        tmo;
        logic [63:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_master_bridge #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .REQ_DEPTH(DEPTH),
        .TIMEOUT  (TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Model state
    req_t  req_q[$];
    plan_t plan_q[$];
    resp_t exp_q[$];
    int    accepted = 0;
    int    started  = 0;

    // Accepted requests, as the spec defines what a stored request looks like.
    initial forever begin
        req_t r;
        @(posedge clk);
        if (rst) begin
            req_q.delete();
            accepted = 0;
        end else if (bus.mem_req_valid && bus.mem_req_ready) begin
            r.we  = bus.mem_we;
            r.sel = (bus.mem_be == 8'h00) ? 8'hFF : bus.mem_be;
            r.adr = bus.mem_addr;
            r.dat = bus.mem_wdata;
            req_q.push_back(r);
            accepted++;
        end
    end

    // Scripted slave plus bus/response scoreboard, evaluated mid-cycle.
    logic  prev_cyc = 1'b0;
    logic  active = 1'b0;
    logic  gap_pending = 1'b0;
    logic  cyc_now, fell, rose;
    int    cur_len, exp_len, slave_cnt, occ;
    plan_t cur_plan;
    initial begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = '0;
        forever begin
            req_t  r;
            resp_t e;
            @(negedge clk);
            if (rst) begin
                started     = 0;
                active      = 1'b0;
                prev_cyc    = 1'b0;
                gap_pending = 1'b0;
                exp_q.delete();
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
            end else begin
                cyc_now = bus.wbm_cyc_o;
                fell = prev_cyc && !cyc_now;
                rose = !prev_cyc && cyc_now;
                if (gap_pending) check("b2b_one_idle_cycle", cyc_now, 1);
                gap_pending = 1'b0;
                check("stb_eq_cyc", bus.wbm_stb_o, cyc_now);
                if (fell) begin
                    check("cyc_length", cur_len, exp_len);
                    active = 1'b0;
                end
                if (rose) begin
                    started++;
                    check("cyc_has_request", req_q.size() != 0, 1);
                    if (req_q.size() != 0) begin
                        r = req_q.pop_front();
                        if (plan_q.size() != 0) cur_plan = plan_q.pop_front();
                        else cur_plan = '{kind: 0, delay: 0, data: 64'h0};
                        check("wb_adr", bus.wbm_adr_o, r.adr);
                        check("wb_we", bus.wbm_we_o, r.we);
                        check("wb_sel", bus.wbm_sel_o, r.sel);
                        check("wb_dat_o", bus.wbm_dat_o, r.dat);
                        if (cur_plan.kind != 3 && cur_plan.delay < TO) begin
                            exp_len = cur_plan.delay + 1;
                            e.err   = (cur_plan.kind != 0);
                            e.tmo   = 1'b0;
                            e.rdata = (cur_plan.kind == 0 && !r.we) ? cur_plan.data : 64'h0;
                        end else begin
                            exp_len = TO;
                            e.err   = 1'b1;
                            e.tmo   = 1'b1;
                            e.rdata = 64'h0;
                        end
                        exp_q.push_back(e);
                        active    = 1'b1;
                        slave_cnt = 0;
                        cur_len   = 0;
                    end
                end
                occ = accepted - started;
                if (fell) gap_pending = (occ > 0);
                check("resp_one_cycle_after_end", bus.mem_resp_valid, fell);
                if (bus.mem_resp_valid) begin
                    check("resp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("resp_err", bus.mem_resp_err, e.err);
                        check("resp_timeout", bus.mem_resp_timeout, e.tmo);
                        check("resp_rdata", bus.mem_rdata, e.rdata);
                    end
                end
                if (!cyc_now) check("we_low_when_idle", bus.wbm_we_o, 0);
                check("req_ready", bus.mem_req_ready, occ != DEPTH);
                check("busy", bus.busy, (occ != 0) || cyc_now);
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                bus.wbm_dat_i = {$urandom, $urandom};
                if (active) begin
                    cur_len++;
                    if (cur_plan.kind != 3 && slave_cnt == cur_plan.delay) begin
                        bus.wbm_ack_i = (cur_plan.kind != 1);
                        bus.wbm_err_i = (cur_plan.kind != 0);
                        if (cur_plan.kind == 0) bus.wbm_dat_i = cur_plan.data;
                    end
                    slave_cnt++;
                end
                prev_cyc = cyc_now;
            end
        end
    end

    // Drive one request at a negedge, return at the negedge after it was accepted.
    task automatic push_req(input logic we, input logic [7:0] be, input logic [31:0] adr,
                            input logic [63:0] dat, input int kind, input int delay,
                            input logic [63:0] rdat);
        int n = 0;
        plan_t p;
        p.kind  = kind;
        p.delay = delay;
        p.data  = rdat;
        plan_q.push_back(p);
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = we;
        bus.mem_be        = be;
        bus.mem_addr      = adr;
        bus.mem_wdata     = dat;
        while (!bus.mem_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted_in_time", bus.mem_req_ready, 1);
        @(negedge clk);
    endtask

    task automatic req_idle();
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'($urandom);
        bus.mem_be        = 8'($urandom);
        bus.mem_addr      = $urandom;
        bus.mem_wdata     = {$urandom, $urandom};
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!bus.mem_resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("resp_arrived", bus.mem_resp_valid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0 || bus.wbm_cyc_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drained", (exp_q.size() == 0) && !bus.wbm_cyc_o, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] wd;
        req_idle();
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", bus.mem_req_ready, 0);
        check("rst_resp_valid", bus.mem_resp_valid, 0);
        check("rst_rdata", bus.mem_rdata, 0);
        check("rst_resp_err", bus.mem_resp_err, 0);
        check("rst_resp_tmo", bus.mem_resp_timeout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_we", bus.wbm_we_o, 0);
        check("rst_sel", bus.wbm_sel_o, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_dat", bus.wbm_dat_o, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.mem_req_ready, 1);

        // Single read, be 0, ACK on second bus cycle
        push_req(1'b0, 8'h00, 32'h100, 64'h0, 0, 1, 64'hDEADBEEF);
        req_idle();
        check("rd_cyc_not_yet", bus.wbm_cyc_o, 0);
        check("rd_busy_queued", bus.busy, 1);
        @(negedge clk);
        check("rd_cyc", bus.wbm_cyc_o, 1);
        check("rd_sel_full", bus.wbm_sel_o, 8'hFF);
        check("rd_we", bus.wbm_we_o, 0);
        check("rd_adr", bus.wbm_adr_o, 32'h100);
        @(negedge clk);
        check("rd_no_resp_yet", bus.mem_resp_valid, 0);
        @(negedge clk);
        check("rd_resp_valid", bus.mem_resp_valid, 1);
        check("rd_rdata", bus.mem_rdata, 64'hDEADBEEF);
        check("rd_err", bus.mem_resp_err, 0);
        @(negedge clk);
        check("rd_resp_pulse", bus.mem_resp_valid, 0);
        check("rd_rdata_held", bus.mem_rdata, 64'hDEADBEEF);

        // Write, ACK at first bus edge: response after N+2
        push_req(1'b1, 8'h0F, 32'h40, 64'h1122334455667788, 0, 0, 64'h0);
        req_idle();
        @(negedge clk);
        check("wr_cyc", bus.wbm_cyc_o, 1);
        check("wr_we", bus.wbm_we_o, 1);
        @(negedge clk);
        check("wr_resp_valid", bus.mem_resp_valid, 1);
        check("wr_rdata_zero", bus.mem_rdata, 0);
        wait_drain();

        // Burst of three writes on consecutive cycles
        push_req(1'b1, 8'hFF, 32'h200, 64'hA, 0, 1, 64'h0);
        push_req(1'b1, 8'h03, 32'h204, 64'hB, 0, 1, 64'h0);
        push_req(1'b1, 8'h00, 32'h208, 64'hC, 0, 1, 64'h0);
        check("burst_fifo_full", bus.mem_req_ready, 0);
        req_idle();
        wait_drain();

        // ERR and ACK together on a read
        push_req(1'b0, 8'h00, 32'h300, 64'h0, 2, 0, 64'hFFFF);
        req_idle();
        wait_resp();
        check("err_resp_err", bus.mem_resp_err, 1);
        check("err_resp_tmo", bus.mem_resp_timeout, 0);
        check("err_rdata", bus.mem_rdata, 0);
        check("err_cyc_low", bus.wbm_cyc_o, 0);
        wait_drain();

        // Silent slave times out, queued write then proceeds
        push_req(1'b0, 8'h00, 32'h400, 64'h0, 3, 0, 64'h0);
        push_req(1'b1, 8'hF0, 32'h404, 64'h55, 0, 0, 64'h0);
        req_idle();
        wait_resp();
        check("tmo_resp_err", bus.mem_resp_err, 1);
        check("tmo_resp_tmo", bus.mem_resp_timeout, 1);
        wait_drain();

        // Reset while a cycle is open and one request is queued
        push_req(1'b0, 8'h00, 32'h500, 64'h0, 3, 0, 64'h0);
        push_req(1'b0, 8'h00, 32'h504, 64'h0, 0, 0, 64'h1);
        req_idle();
        check("pre_rst_cyc", bus.wbm_cyc_o, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cyc", bus.wbm_cyc_o, 0);
        check("mid_rst_stb", bus.wbm_stb_o, 0);
        check("mid_rst_busy", bus.busy, 0);
        plan_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_cyc", bus.wbm_cyc_o, 0);

        // Byte selects on the wide bus
        wd = {$urandom, $urandom};
        push_req(1'b1, 8'hF0, 32'h208, wd, 0, 0, 64'h0);
        req_idle();
        @(negedge clk);
        check("wide_sel", bus.wbm_sel_o, 8'hF0);
        check("wide_dat", bus.wbm_dat_o, wd);
        @(negedge clk);
        check("wide_resp_valid", bus.mem_resp_valid, 1);
        check("wide_resp_err", bus.mem_resp_err, 0);
        wait_drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            int k, d;
            k = int'($urandom_range(0, 9));
            k = (k < 6) ? 0 : k - 6;
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 10))
                                            : int'($urandom_range(0, 3));
            push_req(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                     $urandom, {$urandom, $urandom}, k, d, {$urandom, $urandom});
            req_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
